kart_physics: RTL and testbench

- Per-frame kart motion engine, directly upstream of the racer view renderer.
- Once per video frame it samples the player controls and the terrain type under the kart, then updates heading, speed and map position.
- It drives the renderer's direction (0..359 degrees, 0 = up/decreasing y) and player_x/player_y (0..2047) inputs.
- Outputs change only in one commit cycle per frame and are held stable otherwise.

---
 rtl/kart_pkg.sv | 44 ++++
 rtl/kart_trig_lut.sv | 35 +++
 rtl/kart_physics.sv | 146 ++++++++++++++
 tb/tb_kart_physics.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/kart_pkg.sv
// Shared types, widths and the trig table generator for the kart motion engine.
package kart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSteer,
        StTrigWait,
        StMul,
        StCommit
    } kart_state_e;

    localparam logic [3:0] TERRAIN_ROAD = 4'd0;
    localparam int POS_INT_W  = 11;
    localparam int POS_FRAC_W = 4;
    localparam int POS_W      = POS_INT_W + POS_FRAC_W;
    localparam int TRIG_FRAC  = 9;
    localparam int TRIG_W     = 11;
    localparam int MAP_MAX    = 2047;
    localparam int DIR_W      = 9;
    localparam int SPEED_W    = 7;
    localparam int DEG_FULL   = 360;

    // Elaboration-time round(512*sin(deg)) via a Q30 Taylor series on the first quadrant.
    function automatic logic signed [TRIG_W-1:0] sin_q9(input int unsigned deg);
        longint      x, x2, term, sum, mag;
        int unsigned d;
        logic        neg;
        d   = deg % 360;
        neg = (d > 180);
        if (neg) d = d - 180;
        if (d > 90) d = 180 - d;
        x    = (longint'(d) * 64'sd3373259426) / 180;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        mag = (sum * 512 + (64'sd1 <<< 29)) >>> 30;
        return neg ? TRIG_W'(-mag) : TRIG_W'(mag);
    endfunction

endpackage

// File: rtl/kart_trig_lut.sv
// Sine/cosine ROM pair indexed by heading in degrees, two-cycle registered read.
module kart_trig_lut
    import kart_pkg::*;
(
    input  logic                     clk_in,
    input  logic [DIR_W-1:0]         angle_in,
    output logic signed [TRIG_W-1:0] sin_out,
    output logic signed [TRIG_W-1:0] cos_out
);

    logic signed [TRIG_W-1:0] w_sin_rom [DEG_FULL];
    logic signed [TRIG_W-1:0] w_cos_rom [DEG_FULL];
    logic [DIR_W-1:0]         w_idx;
    logic signed [TRIG_W-1:0] r_sin_s1, r_cos_s1, r_sin_s2, r_cos_s2;

    for (genvar g = 0; g < DEG_FULL; g++) begin : g_rom
        localparam logic signed [TRIG_W-1:0] SIN_VAL = sin_q9(g);
        localparam logic signed [TRIG_W-1:0] COS_VAL = sin_q9(g + 90);
        assign w_sin_rom[g] = SIN_VAL;
        assign w_cos_rom[g] = COS_VAL;
    end

    assign w_idx = (angle_in < DIR_W'(DEG_FULL)) ? angle_in : '0;

    always_ff @(posedge clk_in) begin
        r_sin_s1 <= w_sin_rom[w_idx];
        r_cos_s1 <= w_cos_rom[w_idx];
        r_sin_s2 <= r_sin_s1;
        r_cos_s2 <= r_cos_s1;
    end

    assign sin_out = r_sin_s2;
    assign cos_out = r_cos_s2;

endmodule

// File: rtl/kart_physics.sv
// Per-frame kart motion engine: steering, speed and Q11.4 position update
// feeding the racer view renderer.
module kart_physics
    import kart_pkg::*;
#(
    parameter int unsigned INIT_X      = 1024,
    parameter int unsigned INIT_Y      = 1024,
    parameter int unsigned INIT_DIR    = 0,
    parameter int unsigned ACCEL       = 2,
    parameter int unsigned BRAKE       = 4,
    parameter int unsigned FRICTION    = 1,
    parameter int unsigned MAX_SPEED   = 64,
    parameter int unsigned OFFROAD_MAX = 32,
    parameter int unsigned TURN_RATE   = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_tick_in,
    input  logic                 btn_accel_in,
    input  logic                 btn_brake_in,
    input  logic                 btn_left_in,
    input  logic                 btn_right_in,
    input  logic [3:0]           terrain_in,
    output logic [DIR_W-1:0]     direction_out,
    output logic [POS_INT_W-1:0] player_x_out,
    output logic [POS_INT_W-1:0] player_y_out,
    output logic [SPEED_W-1:0]   speed_out,
    output logic                 update_done_out
);

    localparam int PROD_W = SPEED_W + TRIG_W;
    localparam logic signed [PROD_W-1:0] POS_MAX = PROD_W'(MAP_MAX << POS_FRAC_W);

    kart_state_e              r_state, w_state_next;
    logic                     r_wait, r_done;
    logic [DIR_W-1:0]         r_dir, r_dir_next, w_dir_calc, w_dir_sum;
    logic [SPEED_W-1:0]       r_speed, r_speed_next, w_speed_calc, w_cap;
    logic [SPEED_W:0]         w_speed_up;
    logic [POS_W-1:0]         r_x, r_y, w_x_calc, w_y_calc;
    logic signed [TRIG_W-1:0] w_sin, w_cos;
    logic signed [PROD_W-1:0] w_sin_ext, w_cos_ext, w_spd_ext;
    logic signed [PROD_W-1:0] r_prod_x, r_prod_y, w_x_sum, w_y_sum;

    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [PROD_W-1:0] v);
        if (v < 0) return '0;
        if (v > POS_MAX) return POS_MAX[POS_W-1:0];
        return v[POS_W-1:0];
    endfunction

    kart_trig_lut u_trig (
        .clk_in   (clk_in),
        .angle_in (r_dir_next),
        .sin_out  (w_sin),
        .cos_out  (w_cos)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (frame_tick_in) w_state_next = StSteer;
            StSteer:    w_state_next = StTrigWait;
            StTrigWait: if (r_wait) w_state_next = StMul;
            StMul:      w_state_next = StCommit;
            StCommit:   w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_dir_sum  = r_dir + DIR_W'(TURN_RATE);
        w_dir_calc = r_dir;
        if (r_speed != '0 && (btn_left_in != btn_right_in)) begin
            if (btn_left_in) begin
                w_dir_calc = (r_dir < DIR_W'(TURN_RATE)) ? r_dir + DIR_W'(DEG_FULL - TURN_RATE)
                                                         : r_dir - DIR_W'(TURN_RATE);
            end else begin
                w_dir_calc = (w_dir_sum >= DIR_W'(DEG_FULL)) ? w_dir_sum - DIR_W'(DEG_FULL)
                                                             : w_dir_sum;
            end
        end
    end

    always_comb begin
        w_cap      = (terrain_in == TERRAIN_ROAD) ? SPEED_W'(MAX_SPEED) : SPEED_W'(OFFROAD_MAX);
        w_speed_up = {1'b0, r_speed} + (SPEED_W + 1)'(ACCEL);
        if (btn_brake_in) begin
            w_speed_calc = (r_speed > SPEED_W'(BRAKE)) ? r_speed - SPEED_W'(BRAKE) : '0;
        end else if (btn_accel_in) begin
            w_speed_calc = (w_speed_up > {1'b0, w_cap}) ? w_cap : w_speed_up[SPEED_W-1:0];
        end else begin
            w_speed_calc = (r_speed > SPEED_W'(FRICTION)) ? r_speed - SPEED_W'(FRICTION) : '0;
        end
        // Entering off-road above its cap drops straight to the cap this frame.
        if (w_speed_calc > w_cap) w_speed_calc = w_cap;
    end

    assign w_sin_ext = {{(PROD_W - TRIG_W){w_sin[TRIG_W-1]}}, w_sin};
    assign w_cos_ext = {{(PROD_W - TRIG_W){w_cos[TRIG_W-1]}}, w_cos};
    assign w_spd_ext = $signed({{TRIG_W{1'b0}}, r_speed_next});

    assign w_x_sum  = $signed({{(PROD_W - POS_W){1'b0}}, r_x}) + (r_prod_x >>> TRIG_FRAC);
    assign w_y_sum  = $signed({{(PROD_W - POS_W){1'b0}}, r_y}) - (r_prod_y >>> TRIG_FRAC);
    assign w_x_calc = clamp_pos(w_x_sum);
    assign w_y_calc = clamp_pos(w_y_sum);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= StIdle;
            r_wait       <= 1'b0;
            r_done       <= 1'b0;
            r_dir        <= DIR_W'(INIT_DIR);
            r_dir_next   <= DIR_W'(INIT_DIR);
            r_speed      <= '0;
            r_speed_next <= '0;
            r_x          <= POS_W'(INIT_X << POS_FRAC_W);
            r_y          <= POS_W'(INIT_Y << POS_FRAC_W);
            r_prod_x     <= '0;
            r_prod_y     <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= (r_state == StTrigWait) && !r_wait;
            r_done  <= (r_state == StCommit);
            if (r_state == StSteer) begin
                r_dir_next   <= w_dir_calc;
                r_speed_next <= w_speed_calc;
            end
            if (r_state == StMul) begin
                r_prod_x <= w_spd_ext * w_sin_ext;
                r_prod_y <= w_spd_ext * w_cos_ext;
            end
            if (r_state == StCommit) begin
                r_dir   <= r_dir_next;
                r_speed <= r_speed_next;
                r_x     <= w_x_calc;
                r_y     <= w_y_calc;
            end
        end
    end

    assign direction_out   = r_dir;
    assign speed_out       = r_speed;
    assign player_x_out    = r_x[POS_W-1:POS_FRAC_W];
    assign player_y_out    = r_y[POS_W-1:POS_FRAC_W];
    assign update_done_out = r_done;

endmodule

// File: tb/tb_kart_physics.sv
// Scoreboard bench for kart_physics: frames push predicted outputs, a monitor
// pops and compares on every update_done_out pulse.
module tb_kart_physics;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ba = 1'b0, bb = 1'b0, bl = 1'b0, br = 1'b0;
    logic [3:0] terr = 4'd0;
    logic [8:0] dir;
    logic [10:0] px, py;
    logic [6:0] spd;
    logic       done;

    kart_physics dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .frame_tick_in   (tick),
        .btn_accel_in    (ba),
        .btn_brake_in    (bb),
        .btn_left_in     (bl),
        .btn_right_in    (br),
        .terrain_in      (terr),
        .direction_out   (dir),
        .player_x_out    (px),
        .player_y_out    (py),
        .speed_out       (spd),
        .update_done_out (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dir;
        int x;
        int y;
        int spd;
        int t;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_dir, m_x, m_y, m_spd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int trig(input int deg);
        real v;
        v = 512.0 * $sin(real'(deg) * 3.14159265358979323846 / 180.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int clamp_q4(input int v);
        if (v < 0) return 0;
        if (v > 2047 * 16) return 2047 * 16;
        return v;
    endfunction

    task automatic model_reset();
        m_dir = 0;
        m_x   = 1024 * 16;
        m_y   = 1024 * 16;
        m_spd = 0;
    endtask

    task automatic model_frame(input bit a, input bit b, input bit l, input bit r, input int ter);
        int cap;
        if (m_spd != 0 && l != r) m_dir = l ? (m_dir + 360 - 3) % 360 : (m_dir + 3) % 360;
        cap = (ter == 0) ? 64 : 32;
        if (b) m_spd = (m_spd - 4 < 0) ? 0 : m_spd - 4;
        else if (a) m_spd = (m_spd + 2 > cap) ? cap : m_spd + 2;
        else m_spd = (m_spd - 1 < 0) ? 0 : m_spd - 1;
        if (m_spd > cap) m_spd = cap;
        m_x = clamp_q4(m_x + int'($floor(real'(m_spd * trig(m_dir)) / 512.0)));
        m_y = clamp_q4(m_y - int'($floor(real'(m_spd * trig(m_dir + 90)) / 512.0)));
    endtask

    // One frame; busy adds a second tick two edges after the accepted one.
    task automatic frame(input bit a, input bit b, input bit l, input bit r, input int ter,
                         input bit busy);
        exp_t e;
        @(negedge clk);
        ba = a; bb = b; bl = l; br = r; terr = 4'(ter);
        @(negedge clk);
        tick = 1'b1;
        e.t = cyc;
        model_frame(a, b, l, r, ter);
        e.dir = m_dir; e.x = m_x / 16; e.y = m_y / 16; e.spd = m_spd;
        sb.push_back(e);
        @(negedge clk);
        tick = 1'b0;
        if (busy) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
        repeat (7) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL done_without_frame: got done pulse, expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dir", int'(dir), e.dir);
                check("x", int'(px), e.x);
                check("y", int'(py), e.y);
                check("speed", int'(spd), e.spd);
                check("latency", cyc - e.t, 6);
            end
        end
    end

    initial begin
        int saved_dir;
        int coast_exp [4];
        coast_exp = '{2, 1, 0, 0};
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dir", int'(dir), 0);
        check("rst_x", int'(px), 1024);
        check("rst_y", int'(py), 1024);
        check("rst_speed", int'(spd), 0);
        check("rst_done", int'(done), 0);

        for (int i = 0; i < 8; i++) frame(1, 0, 0, 0, 0, 0);
        check("accel_speed", int'(spd), 16);
        check("accel_y", int'(py), 1019);
        check("accel_x", int'(px), 1024);

        frame(1, 0, 1, 0, 0, 0);
        check("wrap_left", int'(dir), 357);
        frame(1, 0, 0, 1, 0, 0);
        check("wrap_right", int'(dir), 0);
        frame(1, 0, 1, 1, 0, 0);
        check("both_held", int'(dir), 0);
        for (int i = 0; i < 40 && m_spd != 0; i++) frame(0, 1, 0, 0, 0, 0);
        saved_dir = m_dir;
        frame(0, 0, 1, 0, 0, 0);
        check("no_steer_at_rest", int'(dir), saved_dir);

        for (int i = 0; i < 60 && m_dir != 90; i++) frame(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 400 && m_x != 2047 * 16; i++) frame(1, 0, 0, 0, 0, 0);
        check("x_clamp_hi", int'(px), 2047);
        frame(1, 0, 0, 0, 0, 0);
        frame(1, 0, 0, 0, 0, 0);
        check("x_stays_hi", int'(px), 2047);
        for (int i = 0; i < 80 && m_dir != 270; i++) frame(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 800 && m_x != 0; i++) frame(1, 0, 0, 0, 0, 0);
        check("x_clamp_lo", int'(px), 0);
        check("top_speed", int'(spd), 64);

        frame(1, 0, 0, 0, 1, 0);
        check("offroad_cap", int'(spd), 32);
        frame(1, 0, 0, 0, 1, 0);
        check("offroad_hold", int'(spd), 32);
        frame(1, 1, 0, 0, 1, 0);
        check("brake_wins", int'(spd), 28);

        for (int i = 0; i < 20 && m_spd > 4; i++) frame(0, 1, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 1);
        check("busy_coast", int'(spd), 3);
        for (int i = 0; i < 4; i++) begin
            frame(0, 0, 0, 0, 0, 0);
            check("coast", int'(spd), coast_exp[i]);
        end

        for (int i = 0; i < 200; i++) begin
            frame($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0,
                  $urandom_range(0, 7) == 0);
        end

        // Abort an update between E+3 and E+4.
        @(negedge clk);
        ba = 1'b1; bb = 1'b0; bl = 1'b1; br = 1'b0; terr = 4'd0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_dir", int'(dir), 0);
        check("abort_x", int'(px), 1024);
        check("abort_y", int'(py), 1024);
        check("abort_speed", int'(spd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        frame(1, 0, 0, 0, 0, 0);
        check("post_abort_speed", int'(spd), 2);

        check("pending_frames", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
